// File: rtl/vga_pkg.sv
// Shared VGA constants and types for the scan timer and the display-colour mux.
package vga_pkg;

  localparam int X_W     = 11;
  localparam int Y_W     = 11;
  localparam int ADDR_W  = X_W + Y_W;
  localparam int COLOR_W = 3;

  // 640x480@60 (25.175 MHz pixel clock)
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  // 1024x768@60 (65 MHz pixel clock)
  localparam int VGA1024_H_ACTIVE = 1024;
  localparam int VGA1024_H_FP     = 24;
  localparam int VGA1024_H_SYNC   = 136;
  localparam int VGA1024_H_BP     = 160;
  localparam int VGA1024_V_ACTIVE = 768;
  localparam int VGA1024_V_FP     = 3;
  localparam int VGA1024_V_SYNC   = 6;
  localparam int VGA1024_V_BP     = 29;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } vga_color_t;

  // Raw (polarity-free) timing flags carried down the latency pipeline.
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } vga_tim_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: wrapping position counter with active/sync window decode.
module vga_axis_counter #(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int W      = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_tick,
  output logic [W-1:0] o_count,
  output logic         o_wrap,
  output logic         o_active,
  output logic         o_sync_raw
);

  localparam int             TOTAL    = ACTIVE + FP + SYNC + BP;
  localparam logic [W-1:0]   LAST     = W'(TOTAL - 1);
  // Window bounds are one bit wider so a window ending at 2**W still decodes.
  localparam logic [W:0]     ACT_END  = (W+1)'(ACTIVE);
  localparam logic [W:0]     SYNC_BEG = (W+1)'(ACTIVE + FP);
  localparam logic [W:0]     SYNC_END = (W+1)'(ACTIVE + FP + SYNC);

  logic [W-1:0] r_count;
  logic [W:0]   w_cnt_x;
  logic         w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_count <= '0;
    else if (i_tick) r_count <= w_last ? '0 : r_count + W'(1);
  end

  assign w_last     = (r_count == LAST);
  assign w_cnt_x    = {1'b0, r_count};
  assign o_count    = r_count;
  assign o_wrap     = i_tick & w_last;
  assign o_active   = (w_cnt_x < ACT_END);
  assign o_sync_raw = (w_cnt_x >= SYNC_BEG) && (w_cnt_x < SYNC_END);

endmodule

// File: rtl/vga_scan_timer.sv
// VGA scan engine: pixel address generation plus latency-matched colour/sync pins.
module vga_scan_timer
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int SYNC_POL  = 0,
  parameter int COLOR_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  input  logic [2:0]  display_color,
  output logic [21:0] display_addr,
  output logic        addr_valid,
  output logic        vga_r,
  output logic        vga_g,
  output logic        vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_start
);

  localparam logic SYNC_IDLE = logic'(SYNC_POL == 0);

  logic [X_W-1:0] w_h_cnt;
  logic [Y_W-1:0] w_v_cnt;
  logic           w_h_wrap, w_v_wrap, w_v_tick;
  logic           w_h_act, w_v_act, w_h_sync, w_v_sync;
  vga_tim_t       w_stg0, w_del;
  vga_color_t     r_rgb;
  logic           r_hs, r_vs, r_frame;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(X_W)
  ) u_h_axis (
    .clk(clk), .rst(rst), .i_tick(pix_ce),
    .o_count(w_h_cnt), .o_wrap(w_h_wrap), .o_active(w_h_act), .o_sync_raw(w_h_sync)
  );

  assign w_v_tick = w_h_wrap & pix_ce;

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(Y_W)
  ) u_v_axis (
    .clk(clk), .rst(rst), .i_tick(w_v_tick),
    .o_count(w_v_cnt), .o_wrap(w_v_wrap), .o_active(w_v_act), .o_sync_raw(w_v_sync)
  );

  assign display_addr = {w_v_cnt, w_h_cnt};
  assign addr_valid   = w_h_act & w_v_act;
  assign w_stg0       = '{active: addr_valid, hs: w_h_sync, vs: w_v_sync};

  // Delay the timing flags by the colour fetch latency so pins stay aligned.
  generate
    if (COLOR_LAT == 0) begin : g_no_dly
      assign w_del = w_stg0;
    end else begin : g_dly
      vga_tim_t [COLOR_LAT-1:0] r_dly;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_dly <= '0;
        end else if (pix_ce) begin
          r_dly[0] <= w_stg0;
          for (int k = 1; k < COLOR_LAT; k++) r_dly[k] <= r_dly[k-1];
        end
      end
      assign w_del = r_dly[COLOR_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rgb   <= '0;
      r_hs    <= SYNC_IDLE;
      r_vs    <= SYNC_IDLE;
      r_frame <= 1'b0;
    end else begin
      // Both wraps already carry pix_ce, so this is 0 on held cycles.
      r_frame <= w_h_wrap & w_v_wrap;
      if (pix_ce) begin
        r_rgb <= w_del.active ? vga_color_t'(display_color) : '0;
        r_hs  <= w_del.hs ^ SYNC_IDLE;
        r_vs  <= w_del.vs ^ SYNC_IDLE;
      end
    end
  end

  assign vga_r       = r_rgb.r;
  assign vga_g       = r_rgb.g;
  assign vga_b       = r_rgb.b;
  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign frame_start = r_frame;

endmodule

// File: tb/tb_vga_scan_timer.sv
// Bench for vga_scan_timer: two instances (COLOR_LAT 1 and 3) on a reduced raster against a position-history model.
module tb_vga_scan_timer;

  localparam int HA = 16, HF = 4, HS = 6, HB = 5;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_ce = 1'b0;
  logic [2:0]  col_a, col_b;
  logic [21:0] addr_a, addr_b;
  logic av_a, av_b, r_a, g_a, b_a, r_b, g_b, b_b;
  logic hs_a, vs_a, hs_b, vs_b, fs_a, fs_b;

  always #5 clk = ~clk;

  vga_scan_timer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(0), .COLOR_LAT(1)
  ) u_dut_a (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .display_color(col_a),
    .display_addr(addr_a), .addr_valid(av_a),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
    .vga_hs(hs_a), .vga_vs(vs_a), .frame_start(fs_a)
  );

  vga_scan_timer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(0), .COLOR_LAT(3)
  ) u_dut_b (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .display_color(col_b),
    .display_addr(addr_b), .addr_valid(av_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
    .vga_hs(hs_b), .vga_vs(vs_b), .frame_start(fs_b)
  );

  int vectors = 0;
  int miscompares = 0;
  int seed;
  // Model: current raster position plus history; q*[k] = position k pixel ticks ago.
  int mx, my;
  int qx[4], qy[4];
  bit qv[4];
  logic [2:0] e_rgb[2];
  logic e_hs[2], e_vs[2];
  int cyc = 0, last_fs = -1, period = -1, mark;

  function automatic logic [2:0] colf(int x, int y);
    return 3'((x ^ (y * 5) ^ seed) & 7);
  endfunction

  function automatic bit act(int x, int y);
    return (x < HA) && (y < VA);
  endfunction

  function automatic logic [2:0] src(int k);
    if (qv[k] && act(qx[k], qy[k])) return colf(qx[k], qy[k]);
    return 3'bxxx;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 0;
    qx[0] = 0; qy[0] = 0; qv[0] = 1'b1;
    for (int i = 1; i < 4; i++) begin qx[i] = 0; qy[i] = 0; qv[i] = 1'b0; end
    for (int d = 0; d < 2; d++) begin e_rgb[d] = 3'b000; e_hs[d] = 1'b1; e_vs[d] = 1'b1; end
  endtask

  task automatic pin_from(input int d, input int k);
    if (!qv[k]) begin
      e_rgb[d] = 3'b000; e_hs[d] = 1'b1; e_vs[d] = 1'b1;
    end else begin
      e_rgb[d] = act(qx[k], qy[k]) ? colf(qx[k], qy[k]) : 3'b000;
      e_hs[d]  = !((qx[k] >= HA + HF) && (qx[k] < HA + HF + HS));
      e_vs[d]  = !((qy[k] >= VA + VF) && (qy[k] < VA + VF + VS));
    end
  endtask

  task automatic check_all(input logic fs_exp);
    logic [21:0] ea;
    ea = {my[10:0], mx[10:0]};
    vectors++;
    chk("addr_a", 32'(addr_a), 32'(ea));
    chk("addr_b", 32'(addr_b), 32'(ea));
    chk("valid_a", 32'(av_a), 32'(act(mx, my)));
    chk("valid_b", 32'(av_b), 32'(act(mx, my)));
    chk("rgb_a", 32'({r_a, g_a, b_a}), 32'(e_rgb[0]));
    chk("rgb_b", 32'({r_b, g_b, b_b}), 32'(e_rgb[1]));
    chk("hs_a", 32'(hs_a), 32'(e_hs[0]));
    chk("hs_b", 32'(hs_b), 32'(e_hs[1]));
    chk("vs_a", 32'(vs_a), 32'(e_vs[0]));
    chk("vs_b", 32'(vs_b), 32'(e_vs[1]));
    chk("fs_a", 32'(fs_a), 32'(fs_exp));
    chk("fs_b", 32'(fs_b), 32'(fs_exp));
  endtask

  task automatic step(input logic ce);
    logic fs_exp;
    pix_ce = ce;
    col_a  = src(1);
    col_b  = src(3);
    fs_exp = ce && (mx == HT - 1) && (my == VT - 1);
    if (ce) begin pin_from(0, 1); pin_from(1, 3); end
    @(posedge clk);
    cyc++;
    if (ce) begin
      for (int i = 3; i > 0; i--) begin qx[i] = qx[i-1]; qy[i] = qy[i-1]; qv[i] = qv[i-1]; end
      mx++;
      if (mx == HT) begin mx = 0; my++; if (my == VT) my = 0; end
      qx[0] = mx; qy[0] = my; qv[0] = 1'b1;
    end
    #1;
    check_all(fs_exp);
    if (fs_a === 1'b1) begin
      if (last_fs >= 0) period = cyc - last_fs;
      last_fs = cyc;
    end
  endtask

  initial begin
    int guard;
    seed = int'($urandom_range(0, 7));
    col_a = 3'bxxx; col_b = 3'bxxx;
    model_reset();
    #12;
    check_all(1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Continuous pixel enable: frame period is HT*VT clocks.
    repeat (3 * HT * VT) step(1'b1);
    vectors++;
    chk("period_ce1", 32'(period), 32'(HT * VT));

    // Alternating enable doubles the period.
    last_fs = -1; period = -1;
    repeat (3 * HT * VT) begin step(1'b1); step(1'b0); end
    vectors++;
    chk("period_ce_half", 32'(period), 32'(2 * HT * VT));

    // Random enable pattern.
    repeat (1500) step($urandom_range(0, 2) != 0);

    // Asynchronous reset in the middle of the active area.
    guard = 0;
    while (!(mx == 10 && my == 5) && guard < 2000) begin
      step($urandom_range(0, 3) != 0);
      guard++;
    end
    vectors++;
    chk("reach_reset_pos", 32'(guard < 2000), 32'd1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all(1'b0);
    @(negedge clk);
    rst = 1'b0;
    mark = cyc;
    last_fs = -1;
    repeat (HT * VT + 40) step(1'b1);
    vectors++;
    chk("first_fs_after_rst", 32'(last_fs - mark), 32'(HT * VT));

    repeat (300) step($urandom_range(0, 1) != 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
